// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage MIPS32 pipeline
// Merges per-stage stall requests into a 6-bit stall vector, answers MEM-stage
// exceptions/ERET with a one-cycle flush plus new_pc followed by a refill window,
// and runs a sticky stall watchdog.
// Ports: clk, rst (sync, active-high); stallreq_if/id/ex/mem; excepttype_i, cp0_epc_i;
//   stall[5:0] ([0]pc..[5]wb, 1 = stop), flush, new_pc, stall_timeout;
//   stat_sel/stat_cnt only when PIPE_CTRL_STAT_EN is defined (per-request stall counters).
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter int REFILL_CYCLES = 2,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
`ifdef PIPE_CTRL_STAT_EN
  input  logic [1:0]  stat_sel,
  output logic [31:0] stat_cnt,
`endif
  output logic        stall_timeout
);
  localparam int RW = $clog2(REFILL_CYCLES + 1);
  localparam int WW = $clog2(STALL_TIMEOUT + 1) > 16 ? $clog2(STALL_TIMEOUT + 1) : 16;
  localparam logic [WW-1:0] TO = WW'(STALL_TIMEOUT);
  typedef enum logic {IDLE, REFILL} state_t;
  state_t state;
  logic [RW-1:0] refill_cnt;
  logic [WW-1:0] wd_cnt, wd_nxt;
  logic [5:0] stall_enc;
  logic exc;
  always_comb begin
    stall_enc = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
                stallreq_id ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    exc = state == IDLE && excepttype_i != 32'h0;
    flush = exc;
    new_pc = !exc ? 32'h0 : excepttype_i == 32'h0000_000e ? cp0_epc_i : EXC_VECTOR;
    // a flush always drops the stall; REFILL forces the pipe to run
    stall = state == IDLE && !exc ? stall_enc : 6'b000000;
    wd_nxt = stall == 6'b0 || flush ? '0 : wd_cnt == TO ? wd_cnt : wd_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      refill_cnt <= '0;
      wd_cnt <= '0;
      stall_timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_nxt;
      if (wd_nxt == TO) stall_timeout <= 1'b1;
      if (exc) begin
        state <= REFILL;
        refill_cnt <= RW'(REFILL_CYCLES - 1);
      end else if (state == REFILL) begin
        if (refill_cnt == '0) state <= IDLE;
        else refill_cnt <= refill_cnt - 1'b1;
      end
    end
  end
`ifdef PIPE_CTRL_STAT_EN
  logic [31:0] stat_ctr [4];
  logic [3:0] req;
  assign req = {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if};
  // counts raw requests, including ones masked by a higher-priority stage
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt <= '0;
      for (int i = 0; i < 4; i++) stat_ctr[i] <= '0;
    end else begin
      stat_cnt <= stat_ctr[stat_sel];
      if (state != REFILL)
        for (int i = 0; i < 4; i++) stat_ctr[i] <= stat_ctr[i] + 32'(req[i]);
    end
  end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic stallreq_if = 1'b0, stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic [31:0] excepttype_i = '0, cp0_epc_i = '0;
  logic [5:0] stall;
  logic flush, stall_timeout;
  logic [31:0] new_pc;
`ifdef PIPE_CTRL_STAT_EN
  logic [1:0] stat_sel = 2'd0;
  logic [31:0] stat_cnt;
`endif
  pipe_ctrl #(.EXC_VECTOR(32'h20), .REFILL_CYCLES(2), .STALL_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i),
    .stall(stall), .flush(flush), .new_pc(new_pc),
`ifdef PIPE_CTRL_STAT_EN
    .stat_sel(stat_sel), .stat_cnt(stat_cnt),
`endif
    .stall_timeout(stall_timeout));
  always #5 clk = ~clk;
  typedef struct {
    logic r;
    logic [3:0] req;
    logic [31:0] exc, epc;
    logic [5:0] e_stall;
    logic e_flush;
    logic [31:0] e_pc;
    logic e_to;
  } vec_t;
  typedef struct {
    logic [5:0] stall;
    logic flush;
    logic [31:0] pc;
    logic to;
  } exp_t;
  exp_t sb[$];
  vec_t tbl[22];
  int applied = 0, miscompares = 0;
  task automatic step(input vec_t v);
    exp_t e, got;
    rst = v.r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = v.req;
    excepttype_i = v.exc;
    cp0_epc_i = v.epc;
    sb.push_back('{v.e_stall, v.e_flush, v.e_pc, v.e_to});
    @(negedge clk);
    e = sb.pop_front();
    got = '{stall, flush, new_pc, stall_timeout};
    applied++;
    if (got != e) begin
      miscompares++;
      $display("FAIL vec%0d: got stall=%b flush=%b new_pc=%h to=%b, want stall=%b flush=%b new_pc=%h to=%b",
               applied, got.stall, got.flush, got.pc, got.to, e.stall, e.flush, e.pc, e.to);
    end
    @(posedge clk);
    #1;
  endtask
  function automatic vec_t mk(logic r, logic [3:0] req, logic [31:0] exc, logic [31:0] epc,
                              logic [5:0] s, logic f, logic [31:0] pc, logic to);
    vec_t v;
    v = '{r, req, exc, epc, s, f, pc, to};
    return v;
  endfunction
`ifdef PIPE_CTRL_STAT_EN
  task automatic check_stat(input logic [31:0] want, input string name);
    @(negedge clk);
    applied++;
    if (stat_cnt !== want) begin
      miscompares++;
      $display("FAIL %s: stat_cnt=%0d want %0d", name, stat_cnt, want);
    end
    @(posedge clk);
    #1;
  endtask
`endif
  initial begin
    // req = {mem, ex, id, if}
    tbl[0]  = mk(1, 4'b0000, 0, 0, 6'b000000, 0, 0, 0);
    tbl[1]  = mk(0, 4'b1010, 0, 0, 6'b011111, 0, 0, 0);
    tbl[2]  = mk(0, 4'b0010, 0, 0, 6'b000111, 0, 0, 0);
    tbl[3]  = mk(0, 4'b0001, 0, 0, 6'b000011, 0, 0, 0);
    tbl[4]  = mk(0, 4'b0101, 0, 0, 6'b001111, 0, 0, 0);
    tbl[5]  = mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0);
    tbl[6]  = mk(0, 4'b0100, 32'h8, 0, 6'b000000, 1, 32'h20, 0);
    tbl[7]  = mk(0, 4'b0100, 0, 0, 6'b000000, 0, 0, 0);
    tbl[8]  = mk(0, 4'b0100, 0, 0, 6'b000000, 0, 0, 0);
    tbl[9]  = mk(0, 4'b0100, 0, 0, 6'b001111, 0, 0, 0);
    tbl[10] = mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0);
    tbl[11] = mk(0, 4'b1000, 32'he, 32'hbfc00100, 6'b000000, 1, 32'hbfc00100, 0);
    tbl[12] = mk(0, 4'b0000, 32'h8, 0, 6'b000000, 0, 0, 0);
    tbl[13] = mk(0, 4'b0000, 32'h8, 0, 6'b000000, 0, 0, 0);
    tbl[14] = mk(0, 4'b0000, 32'h8, 0, 6'b000000, 1, 32'h20, 0);
    tbl[15] = mk(0, 4'b0000, 32'h8, 0, 6'b000000, 0, 0, 0);
    tbl[16] = mk(0, 4'b0000, 32'h8, 0, 6'b000000, 0, 0, 0);
    tbl[17] = mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0);
    tbl[18] = mk(0, 4'b0000, 32'h4, 32'h1234, 6'b000000, 1, 32'h20, 0);
    tbl[19] = mk(1, 4'b0000, 0, 0, 6'b000000, 0, 0, 0);
    tbl[20] = mk(0, 4'b0100, 0, 0, 6'b001111, 0, 0, 0);
    tbl[21] = mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) step(tbl[i]);
    // flush in the middle of a long stall resets the watchdog
    for (int i = 0; i < 7; i++) step(mk(0, 4'b1000, 0, 0, 6'b011111, 0, 0, 0));
    step(mk(0, 4'b1000, 32'h10, 0, 6'b000000, 1, 32'h20, 0));
    step(mk(0, 4'b1000, 0, 0, 6'b000000, 0, 0, 0));
    step(mk(0, 4'b1000, 0, 0, 6'b000000, 0, 0, 0));
    for (int i = 0; i < 7; i++) step(mk(0, 4'b1000, 0, 0, 6'b011111, 0, 0, 0));
    step(mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0));
    // eight stalled cycles trip the sticky watchdog
    for (int i = 0; i < 8; i++) step(mk(0, 4'b1000, 0, 0, 6'b011111, 0, 0, 0));
    step(mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 1));
    step(mk(0, 4'b0100, 0, 0, 6'b001111, 0, 0, 1));
    step(mk(0, 4'b0000, 32'h8, 0, 6'b000000, 1, 32'h20, 1));
    step(mk(1, 4'b0000, 0, 0, 6'b000000, 0, 0, 1));
    step(mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0));
`ifdef PIPE_CTRL_STAT_EN
    for (int i = 0; i < 5; i++) step(mk(0, 4'b0001, 0, 0, 6'b000011, 0, 0, 0));
    stat_sel = 2'd0;
    step(mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0));
    check_stat(32'd5, "stat_if");
    stat_sel = 2'd1;
    step(mk(0, 4'b0000, 0, 0, 6'b000000, 0, 0, 0));
    check_stat(32'd0, "stat_id");
    stat_sel = 2'd0;
    step(mk(0, 4'b0001, 32'h8, 0, 6'b000000, 1, 32'h20, 0));
    step(mk(0, 4'b0001, 0, 0, 6'b000000, 0, 0, 0));
    check_stat(32'd6, "stat_frozen");
    rst = 1'b1;
    step(mk(1, 4'b0000, 0, 0, 6'b000000, 0, 0, 0));
    step(mk(0, 4'b0100, 0, 0, 6'b001111, 0, 0, 0));
    check_stat(32'd0, "stat_rst");
`endif
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
